// File: rtl/median_seq_sort.sv
`timescale 1ns/1ps
// median_seq_sort: collects a 9-sample window, sorts it in place (odd-even transposition) and reports max/median/min.
// Latency: the 9th sample accepted at edge T gives out_valid after edge T+10 (9 sort phases plus one settle cycle).
// Backpressure: in_ready is low while sorting and holding a result; the result stays in DONE until out_ready.
module median_seq_sort #(
  parameter int DATA_SIZE = 8,
  parameter int WIN       = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_median,
  output logic [DATA_SIZE-1:0] out_max,
  output logic [DATA_SIZE-1:0] out_min,
  output logic                 busy
);

  localparam int         N        = 9;
  // Index of the last sample of a window.
  localparam logic [3:0] LAST_CNT = 4'd8;
  // Phases 0..8 are compare phases; ph==9 is the settle cycle before DONE.
  localparam logic [3:0] END_PH   = 4'd9;

  // The sorting network and phase count are built for exactly nine entries.
  generate
    if (WIN != 9) begin : g_win_check
      $error("median_seq_sort: only WIN=9 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DATA_SIZE-1:0] r_data  [N];
  logic [DATA_SIZE-1:0] w_phase [N];
  logic [3:0]           r_cnt;
  logic [3:0]           r_ph;
  logic                 w_load_fire;

  assign w_load_fire = in_valid && (r_state == LOAD);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: load 9, sort until the settle cycle, hold until taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_load_fire && (r_cnt == LAST_CNT)) w_next = SORT;
      SORT:    if (r_ph == END_PH) w_next = DONE;
      DONE:    if (out_ready) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      LOAD: in_ready = 1'b1;
      SORT: busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // One transposition phase: even ph uses pairs (0,1)..(6,7), odd ph (1,2)..(7,8);
  // larger value goes to the lower index, equal pairs are swapped harmlessly.
  always_comb begin
    w_phase = r_data;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == r_ph[0]) begin
        if (r_data[i] <= r_data[i+1]) begin
          w_phase[i]   = r_data[i+1];
          w_phase[i+1] = r_data[i];
        end
      end
    end
  end

  // Window storage, load counter and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_data[i] <= '0;
      r_cnt <= '0;
      r_ph  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_load_fire) begin
            r_data[r_cnt] <= in_data;
            if (r_cnt == LAST_CNT) begin
              r_cnt <= '0;
              r_ph  <= '0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        SORT: begin
          if (r_ph != END_PH) begin
            r_data <= w_phase;
            r_ph   <= r_ph + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Sorted descending, so the ends and the middle give max, min and median.
  assign out_max    = r_data[0];
  assign out_median = r_data[4];
  assign out_min    = r_data[8];

endmodule
